tdm_demux4: RTL



---
 rtl/tdm_demux4.sv | 79 +++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// Receiver side of the 4:1 TDM mux path: steers consecutive samples into slots 0..3
// and presents each completed set of four as one frame with a valid/ready handshake.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sof,
    output logic             sel0,
    output logic             sel1,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             frame_err
);

    logic [1:0]       slot;
    logic [WIDTH-1:0] s0, s1, s2;
    logic             run;
    logic             accept;

    // NOTE: run is a registered out-of-reset flag, so din_ready is low throughout
    // reset and rises on the first clock after release without gating logic on rst_n.
    assign din_ready = run && !(slot == 2'd3 && frame_valid && !frame_ready);
    assign accept    = din_valid && din_ready;
    assign sel0      = slot[1];
    assign sel1      = slot[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            slot        <= 2'd0;
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            run       <= 1'b1;
            frame_err <= 1'b0;
            // NOTE: the drain clear is written first so that a completing beat later in
            // this block overrides it; the last non-blocking assignment wins.
            if (frame_valid && frame_ready)
                frame_valid <= 1'b0;
            if (accept) begin
                if (sof) begin
                    s0        <= din;
                    slot      <= 2'd1;
                    frame_err <= (slot != 2'd0);
                end else begin
                    case (slot)
                        2'd0: begin s0 <= din; slot <= 2'd1; end
                        2'd1: begin s1 <= din; slot <= 2'd2; end
                        2'd2: begin s2 <= din; slot <= 2'd3; end
                        default: begin
                            y0          <= s0;
                            y1          <= s1;
                            y2          <= s2;
                            y3          <= din;
                            frame_valid <= 1'b1;
                            slot        <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
